// File: rtl/bcd_cnt_pkg.sv
// ============================================================================
// bcd_cnt_pkg : shared BCD types, constants and helper functions  (rev 1.0)
// ============================================================================
`default_nettype none

package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  function automatic int pow10(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value, input int digits);
    logic [4*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (vec[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter_if.sv
// ============================================================================
// bcd_mod_counter_if : control/status bundle; `up` exists only with BCD_CNT_DOWN_EN  (rev 1.0)
// ============================================================================
`default_nettype none

interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
`ifdef BCD_CNT_DOWN_EN
  logic                  up;
`endif
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  wrap;
  logic                  err;

  modport master (
    output en, clr, load, load_val,
`ifdef BCD_CNT_DOWN_EN
    output up,
`endif
    input  count, tc, wrap, err
  );

  modport slave (
    input  en, clr, load, load_val,
`ifdef BCD_CNT_DOWN_EN
    input  up,
`endif
    output count, tc, wrap, err
  );
endinterface

`default_nettype wire

// File: rtl/bcd_digit_step.sv
// ============================================================================
// bcd_digit_step : one BCD digit +/-1 with carry/borrow; down path only with BCD_CNT_DOWN_EN  (rev 1.0)
// ============================================================================
`default_nettype none

module bcd_digit_step
  import bcd_cnt_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       cin,
`ifdef BCD_CNT_DOWN_EN
  input  logic       up,
`endif
  output bcd_digit_t next_digit,
  output logic       cout
);

  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
`ifdef BCD_CNT_DOWN_EN
      if (!up) begin
        if (digit == 4'd0) begin
          next_digit = BCD_MAX;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end else
`endif
      begin
        if (digit == BCD_MAX) begin
          next_digit = 4'd0;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// bcd_mod_counter : DIGITS-digit packed BCD modulo-MODULUS counter; up/down with BCD_CNT_DOWN_EN  (rev 1.0)
// ============================================================================
`default_nettype none

module bcd_mod_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                clk,
  input  logic                reset,
  bcd_mod_counter_if.slave    bus
);

  localparam int                         W         = 4 * DIGITS;
  localparam logic [4*MAX_DIGITS-1:0]    MAX_BCD32 = int_to_bcd(MODULUS - 1, DIGITS);
  localparam logic [W-1:0]               MAX_BCD   = MAX_BCD32[W-1:0];

  if (DIGITS < 1 || DIGITS > MAX_DIGITS || MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_cfg
    $error("bcd_mod_counter: DIGITS or MODULUS out of range");
  end

  logic [W-1:0]    count_r;
  logic            wrap_r;
  logic            err_r;
  logic [W-1:0]    step_val;
  logic [DIGITS:0] carry;
  logic            at_term;
  logic [W-1:0]    wrap_val;
  logic            load_ok;
  logic            unused_carry;

  assign carry[0]     = 1'b1;
  assign unused_carry = carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (count_r[4*i +: 4]),
      .cin        (carry[i]),
`ifdef BCD_CNT_DOWN_EN
      .up         (bus.up),
`endif
      .next_digit (step_val[4*i +: 4]),
      .cout       (carry[i+1])
    );
  end

  // The modulus override replaces the natural digit-chain result at the terminal value.
`ifdef BCD_CNT_DOWN_EN
  assign at_term  = bus.up ? (count_r == MAX_BCD) : (count_r == '0);
  assign wrap_val = bus.up ? '0 : MAX_BCD;
`else
  assign at_term  = (count_r == MAX_BCD);
  assign wrap_val = '0;
`endif

  // For valid BCD, numeric order of the packed vector matches decimal order.
  assign load_ok = bcd_valid((4*MAX_DIGITS)'(bus.load_val)) && (bus.load_val <= MAX_BCD);

  assign bus.tc    = bus.en & ~bus.clr & ~bus.load & at_term;
  assign bus.count = count_r;
  assign bus.wrap  = wrap_r;
  assign bus.err   = err_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (bus.clr) begin
        count_r <= '0;
        err_r   <= 1'b0;
      end else if (bus.load) begin
        if (load_ok) count_r <= bus.load_val;
        else         err_r   <= 1'b1;
      end else if (bus.en) begin
        if (at_term) begin
          count_r <= wrap_val;
          wrap_r  <= 1'b1;
        end else begin
          count_r <= step_val;
        end
      end
    end
  end

endmodule

`default_nettype wire
